// File: rtl/piano_pkg.sv
// Shared types and note constants for the multi-key piano voice bank.
// Half-periods are in clk cycles at CLK_HZ: CLK_HZ / (2 * f_note).
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        PLAY    = 2'b10,
        RELEASE = 2'b11
    } voice_state_t;

    localparam int CLK_HZ = 50_000_000;

    localparam logic [23:0] HP_E3 = 24'd151_686;  // 164.81 Hz
    localparam logic [23:0] HP_C4 = 24'd95_556;   // 261.63 Hz
    localparam logic [23:0] HP_E4 = 24'd75_843;   // 329.63 Hz
    localparam logic [23:0] HP_G4 = 24'd63_776;   // 392.00 Hz
    localparam logic [23:0] HP_A4 = 24'd56_818;   // 440.00 Hz

endpackage

// File: rtl/piano_key_voice.sv
// One key channel: press/release qualification FSM plus square-wave divider.
// A zero half-period mutes the tone while the FSM keeps tracking the key.
module piano_key_voice
    import piano_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int HOLD_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_in,
    input  logic [CNT_W-1:0] half_period,
    output logic             tone,
    output logic             active
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    voice_state_t      state_r, state_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s, reload_s, div_cnt_s;
    logic              tone_r, tone_s, div_tone_s, active_r;

    // Next divider step and next FSM state.
    always_comb begin
        state_s  = state_r;
        hold_s   = hold_r;
        cnt_s    = cnt_r;
        tone_s   = tone_r;
        reload_s = (half_period == '0) ? '0 : (half_period - CNT_W'(1));
        if (cnt_r != '0) begin
            div_cnt_s  = cnt_r - CNT_W'(1);
            div_tone_s = tone_r;
        end else if (half_period == '0) begin
            div_cnt_s  = '0;
            div_tone_s = 1'b0;
        end else begin
            div_cnt_s  = reload_s;
            div_tone_s = ~tone_r;
        end

        case (state_r)
            IDLE: begin
                hold_s  = '0;
                cnt_s   = '0;
                tone_s  = 1'b0;
                state_s = key_in ? ARM : IDLE;
            end
            ARM: begin
                if (!key_in) begin
                    state_s = IDLE;
                    hold_s  = '0;
                end else if (hold_r == HOLD_LAST) begin
                    state_s = PLAY;
                    hold_s  = '0;
                    cnt_s   = reload_s;
                end else begin
                    hold_s  = hold_r + HOLD_W'(1);
                end
            end
            PLAY: begin
                cnt_s  = div_cnt_s;
                tone_s = div_tone_s;
                hold_s = '0;
                if (!key_in) begin
                    state_s = RELEASE;
                end else begin
                    state_s = PLAY;
                end
            end
            RELEASE: begin
                cnt_s  = div_cnt_s;
                tone_s = div_tone_s;
                if (key_in) begin
                    state_s = PLAY;
                    hold_s  = '0;
                end else if (hold_r == HOLD_LAST) begin
                    state_s = IDLE;
                    hold_s  = '0;
                    cnt_s   = '0;
                    tone_s  = 1'b0;
                end else begin
                    hold_s  = hold_r + HOLD_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                hold_s  = '0;
                cnt_s   = '0;
                tone_s  = 1'b0;
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            hold_r   <= '0;
            cnt_r    <= '0;
            tone_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            hold_r   <= hold_s;
            cnt_r    <= cnt_s;
            tone_r   <= tone_s;
            active_r <= (state_s == PLAY) || (state_s == RELEASE);
        end
    end

    assign tone   = tone_r;
    assign active = active_r;

endmodule

// File: rtl/piano_voice_bank.sv
// N independent key voices mixed onto one speaker line by lowest-index priority.
// The select stage is registered, so speaker lags the per-key tones by one cycle.
module piano_voice_bank
    import piano_pkg::*;
#(
    parameter int NUM_KEYS    = 8,
    parameter int CNT_W       = 24,
    parameter int HOLD_CYCLES = 3,
    parameter int IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_KEYS-1:0]       key_in,
    input  logic [NUM_KEYS*CNT_W-1:0] half_period,
    output logic                      speaker,
    output logic [NUM_KEYS-1:0]       tone,
    output logic [NUM_KEYS-1:0]       active,
    output logic [IDX_W-1:0]          sel_key,
    output logic                      any_active
);

    logic [IDX_W-1:0] pick_s, sel_r;
    logic             any_s, any_r, spk_r;

    function automatic logic [IDX_W-1:0] lowest_active(input logic [NUM_KEYS-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx = IDX_W'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_voice
        piano_key_voice #(
            .CNT_W       (CNT_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_voice (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[k]),
            .half_period (half_period[k*CNT_W +: CNT_W]),
            .tone        (tone[k]),
            .active      (active[k])
        );
    end

    // Priority pick over the registered channel outputs.
    always_comb begin
        pick_s = lowest_active(active);
        any_s  = |active;
    end

    // Registered mono select; sel_key is sticky while nothing plays.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_r <= '0;
            any_r <= 1'b0;
            spk_r <= 1'b0;
        end else begin
            any_r <= any_s;
            if (any_s) begin
                sel_r <= pick_s;
                spk_r <= tone[pick_s];
            end else begin
                sel_r <= sel_r;
                spk_r <= 1'b0;
            end
        end
    end

    assign speaker    = spk_r;
    assign sel_key    = sel_r;
    assign any_active = any_r;

endmodule

// File: tb/tb_piano_voice_bank.sv
// Directed bench for piano_voice_bank: 4 keys, HOLD_CYCLES=3, half_period=4 unless changed.
module tb_piano_voice_bank;

    localparam int NK = 4;
    localparam int CW = 8;

    logic           clk;
    logic           rst;
    logic [NK-1:0]  key_in;
    logic [NK*CW-1:0] half_period;
    logic           speaker;
    logic [NK-1:0]  tone;
    logic [NK-1:0]  active;
    logic [1:0]     sel_key;
    logic           any_active;

    int n_checks;
    int n_fail;
    int exp_t;

    piano_voice_bank #(
        .NUM_KEYS    (NK),
        .CNT_W       (CW),
        .HOLD_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .half_period (half_period),
        .speaker     (speaker),
        .tone        (tone),
        .active      (active),
        .sel_key     (sel_key),
        .any_active  (any_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tone"}, 32'(tone), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_speaker"}, 32'(speaker), 32'd0);
        check({tag, "_any"}, 32'(any_active), 32'd0);
        check({tag, "_sel"}, 32'(sel_key), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        key_in      = '0;
        half_period = {NK{8'd4}};
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();
        check_all_zero("idle");

        // Single press on key 1; edge e0 is the first sample of key_in=1.
        key_in[1] = 1'b1;
        repeat (3) tick();
        check("press_wait", 32'(active), 32'd0);
        tick();
        check("press_active", 32'(active), 32'b0010);
        check("press_any_late", 32'(any_active), 32'd0);
        for (int e = 4; e <= 19; e++) begin
            tick();
            exp_t = ((e - 3) / 4) % 2;
            check("press_tone", 32'(tone[1]), 32'(exp_t));
            exp_t = ((e - 4) / 4) % 2;
            check("press_speaker", 32'(speaker), 32'(exp_t));
            check("press_sel", 32'(sel_key), 32'd1);
        end

        // Short release then re-cover: tone phase runs on undisturbed.
        for (int e = 20; e <= 27; e++) begin
            key_in[1] = (e == 20 || e == 21) ? 1'b0 : 1'b1;
            tick();
            check("repress_active", 32'(active[1]), 32'd1);
            exp_t = ((e - 3) / 4) % 2;
            check("repress_tone", 32'(tone[1]), 32'(exp_t));
        end

        // Full release: RELEASE at e28, back to IDLE at e31.
        key_in[1] = 1'b0;
        repeat (3) tick();
        check("release_hold", 32'(active[1]), 32'd1);
        tick();
        check("release_idle", 32'(active), 32'd0);
        check("release_tone", 32'(tone), 32'd0);
        tick();
        check("release_any", 32'(any_active), 32'd0);
        check("release_spk", 32'(speaker), 32'd0);
        check("release_sel_sticky", 32'(sel_key), 32'd1);

        // Glitch: two samples of key_in[0] are rejected.
        key_in[0] = 1'b1;
        for (int g = 0; g < 6; g++) begin
            if (g == 2) key_in[0] = 1'b0;
            tick();
            check("glitch_active", 32'(active), 32'd0);
            check("glitch_spk", 32'(speaker), 32'd0);
        end

        // Priority: key 2 playing, key 0 takes over, then hands back.
        key_in[2] = 1'b1;
        repeat (4) tick();
        check("prio_act2", 32'(active), 32'b0100);
        tick();
        check("prio_sel2", 32'(sel_key), 32'd2);
        check("prio_any", 32'(any_active), 32'd1);
        key_in[0] = 1'b1;
        repeat (4) tick();
        check("prio_act0", 32'(active), 32'b0101);
        check("prio_sel_still2", 32'(sel_key), 32'd2);
        tick();
        check("prio_sel0", 32'(sel_key), 32'd0);
        key_in[0] = 1'b0;
        repeat (3) tick();
        check("prio_rel_hold", 32'(sel_key), 32'd0);
        tick();
        check("prio_rel_act", 32'(active), 32'b0100);
        check("prio_rel_sel_lag", 32'(sel_key), 32'd0);
        tick();
        check("prio_back2", 32'(sel_key), 32'd2);
        key_in[2] = 1'b0;
        repeat (6) tick();
        check("prio_clear", 32'(active), 32'd0);

        // Muted key 3: active but silent.
        half_period[3*CW +: CW] = 8'd0;
        key_in[3] = 1'b1;
        repeat (4) tick();
        check("mute_active", 32'(active), 32'b1000);
        for (int m = 0; m < 8; m++) begin
            tick();
            check("mute_tone", 32'(tone[3]), 32'd0);
        end
        check("mute_sel", 32'(sel_key), 32'd3);
        check("mute_spk", 32'(speaker), 32'd0);

        // Live half-period change on key 1: current half-cycle finishes at 4, then 6.
        key_in[1] = 1'b1;
        repeat (4) tick();
        check("live_active", 32'(active), 32'b1010);
        for (int e = 4; e <= 23; e++) begin
            if (e == 9) half_period[1*CW +: CW] = 8'd6;
            tick();
            if (e < 7)       exp_t = 0;
            else if (e < 11) exp_t = 1;
            else if (e < 17) exp_t = 0;
            else if (e < 23) exp_t = 1;
            else             exp_t = 0;
            check("live_tone", 32'(tone[1]), 32'(exp_t));
        end
        check("live_sel", 32'(sel_key), 32'd1);

        // Reset mid-operation, then held keys must re-arm.
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int r = 0; r < 2; r++) begin
            key_in[0] = ~key_in[0];
            tick();
            check_all_zero("midrst_hold");
        end
        key_in[0] = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("rearm_wait", 32'(active), 32'd0);
        tick();
        check("rearm_active", 32'(active), 32'b1010);
        tick();
        check("rearm_sel", 32'(sel_key), 32'd1);
        check("rearm_any", 32'(any_active), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
